// File: rtl/div_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
//   state_e : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   err_t   : response status code type
//   ERR_*   : status codes (ok, divide-by-zero, divider timeout)
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef logic [1:0] err_t;

    localparam err_t ERR_OK  = 2'b00;
    localparam err_t ERR_DZ  = 2'b01;
    localparam err_t ERR_TMO = 2'b10;

endpackage

// File: rtl/div_rr_scheduler_if.sv
// Bundle of requester handshakes, response bus and divider side-band used by
// div_rr_scheduler.
//   req_valid/req_ready/req_num/req_den : per-requester request channel
//   resp_valid/resp_ready               : per-requester response handshake
//   resp_coc/resp_rec/resp_err          : shared response payload
//   div_start/div_num/div_den           : command to the shared divider
//   div_coc/div_rec/div_done            : result from the shared divider
// master: scheduler side. slave: requesters + divider side.
interface div_rr_scheduler_if
    import div_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_num;
    logic [N_REQ*WIDTH-1:0] req_den;
    logic [N_REQ-1:0]       resp_valid;
    logic [N_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]       resp_coc;
    logic [WIDTH-1:0]       resp_rec;
    err_t                   resp_err;
    logic                   div_start;
    logic [WIDTH-1:0]       div_num;
    logic [WIDTH-1:0]       div_den;
    logic [WIDTH-1:0]       div_coc;
    logic [WIDTH-1:0]       div_rec;
    logic                   div_done;

    modport master (
        input  req_valid, req_num, req_den, resp_ready,
        input  div_coc, div_rec, div_done,
        output req_ready, resp_valid, resp_coc, resp_rec, resp_err,
        output div_start, div_num, div_den
    );

    modport slave (
        output req_valid, req_num, req_den, resp_ready,
        output div_coc, div_rec, div_done,
        input  req_ready, resp_valid, resp_coc, resp_rec, resp_err,
        input  div_start, div_num, div_den
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req : request bits, one per requester
//   ptr : index where the search starts (wraps modulo N_REQ)
//   gnt : one-hot grant of the first set request at or after ptr
//   idx : binary index of the granted requester
//   any : at least one request is set
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] pos;
        pos = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            pos = IDX_W'((32'(ptr) + off) % N_REQ);
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
                gnt = N_REQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/div_rr_scheduler.sv
// Round-robin scheduler sharing one signed sequential divider among N_REQ
// requesters. One request is in flight at a time; divide-by-zero is answered
// without the divider and a watchdog answers with a timeout if the divider
// never reports done.
//   CLK  : clock, rising edge
//   RSTa : asynchronous active-low reset
//   bus  : requester/response/divider signals (div_rr_scheduler_if.master)
module div_rr_scheduler
    import div_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TMO_CYC = 63,
    parameter int unsigned TMO_W   = 6
) (
    input logic                CLK,
    input logic                RSTa,
    div_rr_scheduler_if.master bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [WIDTH-1:0] div_num_q, div_num_d;
    logic [WIDTH-1:0] div_den_q, div_den_d;
    logic [WIDTH-1:0] coc_q,     coc_d;
    logic [WIDTH-1:0] rec_q,     rec_d;
    err_t             err_q,     err_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] sel_num;
    logic [WIDTH-1:0] sel_den;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_num = '0;
        sel_den = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_num = bus.req_num[i*WIDTH +: WIDTH];
                sel_den = bus.req_den[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            div_num_q <= '0;
            div_den_q <= '0;
            coc_q     <= '0;
            rec_q     <= '0;
            err_q     <= ERR_OK;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            div_num_q <= div_num_d;
            div_den_q <= div_den_d;
            coc_q     <= coc_d;
            rec_q     <= rec_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        div_num_d = div_num_q;
        div_den_d = div_den_q;
        coc_d     = coc_q;
        rec_d     = rec_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_idx_d = arb_idx;
                    rr_ptr_d  = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    div_num_d = sel_num;
                    div_den_d = sel_den;
                    if (sel_den == '0) begin
                        coc_d   = '1;
                        rec_d   = sel_num;
                        err_d   = ERR_DZ;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            // div_done is not looked at here: it may still be high from the
            // previous operation until the divider sees this start pulse.
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            // Timeout fires when the counter would reach TMO_CYC, giving
            // TMO_CYC WAIT cycles; done takes priority in the same cycle.
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.div_done) begin
                    coc_d   = bus.div_coc;
                    rec_d   = bus.div_rec;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    coc_d   = '0;
                    rec_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready[gnt_idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by RSTa so every output reads zero while in reset.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.div_start  = 1'b0;
        case (state_q)
            IDLE:    if (RSTa) bus.req_ready = arb_gnt;
            ISSUE:   bus.div_start = 1'b1;
            RESP:    bus.resp_valid = N_REQ'(1) << gnt_idx_q;
            default: ;
        endcase
    end

    assign bus.div_num  = div_num_q;
    assign bus.div_den  = div_den_q;
    assign bus.resp_coc = coc_q;
    assign bus.resp_rec = rec_q;
    assign bus.resp_err = err_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Directed bench for div_rr_scheduler with a behavioural sequential divider.
module tb_div_rr_scheduler;

    logic CLK;
    logic RSTa;

    div_rr_scheduler_if #(.WIDTH(32), .N_REQ(4)) bus ();

    div_rr_scheduler #(
        .WIDTH   (32),
        .N_REQ   (4),
        .TMO_CYC (63),
        .TMO_W   (6)
    ) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Divider model: done rises m_lat cycles after the start pulse and stays
    // high until the next start; m_never suppresses done entirely.
    int unsigned m_lat   = 1;
    bit          m_never = 1'b0;
    int unsigned m_cnt;
    bit          m_busy;

    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            bus.div_done <= 1'b0;
            bus.div_coc  <= '0;
            bus.div_rec  <= '0;
            m_busy       <= 1'b0;
            m_cnt        <= 0;
        end else if (bus.div_start) begin
            bus.div_coc  <= $signed(bus.div_num) / $signed(bus.div_den);
            bus.div_rec  <= $signed(bus.div_num) % $signed(bus.div_den);
            bus.div_done <= (m_lat == 1) && !m_never;
            m_busy       <= !((m_lat == 1) && !m_never);
            m_cnt        <= 1;
        end else if (m_busy) begin
            if (!m_never && (m_cnt + 1 == m_lat)) begin
                bus.div_done <= 1'b1;
                m_busy       <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    int n_rdy   = 0;
    int n_start = 0;
    always @(negedge CLK) begin
        if (RSTa) begin
            n_rdy   += $countones(bus.req_ready);
            n_start += int'(bus.div_start);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_resp(output int unsigned k);
        k = 0;
        while (bus.resp_valid == '0 && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic set_op(input int unsigned i, input logic [31:0] n, input logic [31:0] d);
        bus.req_num[i*32 +: 32] = n;
        bus.req_den[i*32 +: 32] = d;
    endtask

    task automatic consume(input logic [3:0] r);
        bus.resp_ready = r;
        tick();
        bus.resp_ready = '0;
    endtask

    logic [31:0] exp_q [4] = '{32'd10, 32'd7, 32'd5, 32'd4};
    logic [31:0] exp_r [4] = '{32'd0,  32'd0, 32'd2, 32'd3};

    initial begin
        int unsigned k;
        logic [3:0]  seen;

        RSTa           = 1'b0;
        bus.req_valid  = '1;
        bus.req_num    = '0;
        bus.req_den    = '0;
        bus.resp_ready = '0;

        // reset: every output zero, req_ready gated even with valids high
        #12;
        check("rst_req_ready",  32'(bus.req_ready), 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_div_start",  32'(bus.div_start), 32'h0);
        check("rst_div_num",    bus.div_num, 32'h0);
        check("rst_resp_coc",   bus.resp_coc, 32'h0);
        check("rst_resp_err",   32'(bus.resp_err), 32'h0);
        bus.req_valid = '0;
        @(negedge CLK);
        RSTa = 1'b1;
        tick();

        // fairness: all valid, grants 0,1,2,3,0,1,2,3, divider done after 1
        m_lat = 1;
        for (int unsigned i = 0; i < 4; i++) set_op(i, 32'd20 + i, 32'd2 + i);
        bus.req_valid = '1;
        #1;
        for (int unsigned t = 0; t < 8; t++) begin
            int unsigned e;
            e = t % 4;
            check("fair_grant", 32'(bus.req_ready), 32'd1 << e);
            tick();
            wait_resp(k);
            check("fair_latency", k, 32'd2);
            check("fair_resp_valid", 32'(bus.resp_valid), 32'd1 << e);
            check("fair_coc", bus.resp_coc, exp_q[e]);
            check("fair_rec", bus.resp_rec, exp_r[e]);
            bus.resp_ready = '1;
            tick();
            bus.resp_ready = '0;
            if (t == 7) bus.req_valid = '0;
            #1;
        end
        check("fair_ready_pulses", n_rdy, 32'd8);
        check("fair_div_starts", n_start, 32'd8);

        // single request 100/7 on req 0, divider done after 33
        m_lat = 33;
        set_op(0, 32'd100, 32'd7);
        bus.req_valid = 4'b0001;
        #1;
        check("t1_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        check("t1_div_start", 32'(bus.div_start), 32'h1);
        check("t1_div_num", bus.div_num, 32'd100);
        check("t1_div_den", bus.div_den, 32'd7);
        wait_resp(k);
        check("t1_latency", k, 32'd34);
        check("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
        check("t1_coc", bus.resp_coc, 32'd14);
        check("t1_rec", bus.resp_rec, 32'd2);
        check("t1_err", 32'(bus.resp_err), 32'h0);
        bus.resp_ready = 4'b1110;
        tick();
        tick();
        check("t1_hold_valid", 32'(bus.resp_valid), 32'h1);
        check("t1_hold_coc", bus.resp_coc, 32'd14);
        consume(4'b0001);
        check("t1_released", 32'(bus.resp_valid), 32'h0);

        // signed -100/7 on req 2
        m_lat = 3;
        set_op(2, 32'hFFFF_FF9C, 32'd7);
        bus.req_valid = 4'b0100;
        #1;
        check("t2_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        wait_resp(k);
        check("t2_latency", k, 32'd4);
        check("t2_resp_valid", 32'(bus.resp_valid), 32'h4);
        check("t2_coc", bus.resp_coc, 32'hFFFF_FFF2);
        check("t2_rec", bus.resp_rec, 32'hFFFF_FFFE);
        check("t2_err", 32'(bus.resp_err), 32'h0);
        consume(4'b0100);

        // divide-by-zero 55/0 on req 1: answered the cycle after grant
        set_op(1, 32'd55, 32'd0);
        bus.req_valid = 4'b0010;
        #1;
        check("dz_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        check("dz_no_start", 32'(bus.div_start), 32'h0);
        check("dz_resp_valid", 32'(bus.resp_valid), 32'h2);
        check("dz_coc", bus.resp_coc, 32'hFFFF_FFFF);
        check("dz_rec", bus.resp_rec, 32'd55);
        check("dz_err", 32'(bus.resp_err), 32'h1);
        consume(4'b0010);

        // divider never done: timeout 64 cycles after ISSUE
        m_never = 1'b1;
        set_op(3, 32'd9, 32'd4);
        bus.req_valid = 4'b1000;
        #1;
        check("tmo_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        wait_resp(k);
        check("tmo_latency", k, 32'd64);
        check("tmo_resp_valid", 32'(bus.resp_valid), 32'h8);
        check("tmo_coc", bus.resp_coc, 32'h0);
        check("tmo_rec", bus.resp_rec, 32'h0);
        check("tmo_err", 32'(bus.resp_err), 32'h2);
        consume(4'b1000);

        // next request after the timeout: 50 / -7
        m_never = 1'b0;
        m_lat   = 2;
        set_op(0, 32'd50, 32'hFFFF_FFF9);
        bus.req_valid = 4'b0001;
        #1;
        check("post_tmo_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        wait_resp(k);
        check("post_tmo_latency", k, 32'd3);
        check("post_tmo_coc", bus.resp_coc, 32'hFFFF_FFF9);
        check("post_tmo_rec", bus.resp_rec, 32'd1);
        check("post_tmo_err", 32'(bus.resp_err), 32'h0);
        consume(4'b0001);

        // done still high from the previous op must not finish this one early
        m_lat = 6;
        set_op(1, 32'd77, 32'd8);
        bus.req_valid = 4'b0010;
        #1;
        check("stuck_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        check("stuck_issue", 32'(bus.div_start), 32'h1);
        tick();
        check("stuck_not_done", 32'(bus.resp_valid), 32'h0);
        wait_resp(k);
        check("stuck_latency", k, 32'd6);
        check("stuck_coc", bus.resp_coc, 32'd9);
        check("stuck_rec", bus.resp_rec, 32'd5);
        consume(4'b0010);

        // reset in WAIT: outputs clear at once, no response, rr_ptr back to 0
        m_never = 1'b1;
        set_op(2, 32'd5, 32'd1);
        bus.req_valid = 4'b0100;
        #1;
        check("abort_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        bus.req_valid = 4'b1010;
        #2;
        RSTa = 1'b0;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'h0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("abort_div_start", 32'(bus.div_start), 32'h0);
        check("abort_div_num", bus.div_num, 32'h0);
        check("abort_div_den", bus.div_den, 32'h0);
        check("abort_coc", bus.resp_coc, 32'h0);
        check("abort_rec", bus.resp_rec, 32'h0);
        bus.req_valid = '0;
        @(negedge CLK);
        RSTa    = 1'b1;
        m_never = 1'b0;
        m_lat   = 1;
        seen    = '0;
        for (int unsigned c = 0; c < 5; c++) begin
            tick();
            seen |= bus.resp_valid;
        end
        check("abort_no_resp", 32'(seen), 32'h0);
        bus.req_valid = 4'b1010;
        #1;
        check("abort_ptr_reset", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        wait_resp(k);
        check("abort_next_latency", k, 32'd2);
        check("abort_next_valid", 32'(bus.resp_valid), 32'h2);
        check("abort_next_coc", bus.resp_coc, 32'd9);
        check("abort_next_rec", bus.resp_rec, 32'd5);
        consume(4'b0010);

        check("total_ready_pulses", n_rdy, 32'd16);
        check("total_div_starts", n_start, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_rr_scheduler.md
Name: div_rr_scheduler

Overview:
Round-robin scheduler that shares one signed sequential divider among N_REQ requesters. It accepts one request at a time through per-requester valid/ready handshakes, pulses the divider's start input and waits for its done flag. It then returns quotient and remainder to the originating requester. Divide-by-zero is short-circuited without using the divider, and a watchdog recovers from a divider that never reports done.

Parameters:
WIDTH, 32, operand/result width in bits (must match divider)
N_REQ, 4, number of requesters (2..8)
TMO_CYC, 63, watchdog limit in cycles waiting for div_done
TMO_W, 6, counter width, ceil(log2(TMO_CYC+1))

Ports:
CLK  in  1  clock, rising edge
RSTa  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request pending, one bit per requester
req_ready  out  N_REQ  one-hot accept pulse
req_num  in  N_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH], two's complement
req_den  in  N_REQ*WIDTH  divisors, same packing
resp_valid  out  N_REQ  one-hot, response for requester i
resp_ready  in  N_REQ  requester i consumes response
resp_coc  out  WIDTH  quotient
resp_rec  out  WIDTH  remainder
resp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
div_start  out  1  one-cycle start pulse to divider
div_num  out  WIDTH  registered dividend to divider
div_den  out  WIDTH  registered divisor to divider
div_coc  in  WIDTH  divider quotient
div_rec  in  WIDTH  divider remainder
div_done  in  1  divider done flag (level, may stay high)

Behaviour:
- Reset (RSTa=0, async): state=IDLE, rr_ptr=0, all outputs 0, tmo counter 0. Reset mid-operation abandons the request without a response; the divider is assumed reset by the same RSTa.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: the search starts at rr_ptr and wraps modulo N_REQ. The first i with req_valid[i]=1 is granted: req_ready[i]=1 for exactly that cycle (combinational from state and req_valid), operands are latched into div_num/div_den, and gnt_idx=i is stored. rr_ptr becomes (i+1) mod N_REQ. No valid requester: stay in IDLE, rr_ptr unchanged.
- Grant with den==0: skip the divider and go to RESP with coc=all-ones, rec=num, err=01.
- Grant with den!=0: go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle, tmo counter cleared, then WAIT. div_done is ignored in the ISSUE cycle (it may still be high from the previous operation).
- WAIT: tmo counter increments every cycle.
  - div_done=1: capture div_coc/div_rec, set err=00, go to RESP.
  - Counter reaches TMO_CYC before done: coc=0, rec=0, err=10, go to RESP.
  - div_done and timeout in the same cycle: done wins.
- RESP: resp_valid[gnt_idx]=1; resp_coc/rec/err stay stable until resp_ready[gnt_idx]=1, then return to IDLE. resp_ready on other bits is ignored.
- Latency, den!=0: grant cycle, then ISSUE, then WAIT until done, then resp_valid. Earliest resp_valid is 3 cycles after grant when the divider asserts done 1 cycle after start.
- Divide-by-zero: resp_valid asserts in the cycle after grant.
- Back-to-back: a new grant can occur at the earliest in the cycle after the response handshake (IDLE).
- Fairness: with all requesters held valid, grants rotate 0,1,2,...,N_REQ-1,0. A requester is never skipped twice in a row.
- Requester obligations: req_num/req_den must be stable while req_valid=1. Deasserting req_valid before the grant is legal.

Decomposition:
- Package div_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP); err code constants ERR_OK, ERR_DZ, ERR_TMO.
- Sub-module rr_arbiter: combinational round-robin selector; N_REQ bit request in, rr_ptr in, one-hot grant plus index and any_grant out.
- Top-level FSM and datapath registers stay in div_rr_scheduler.

Test Plan:
- Single request, req 0: num=100, den=7, divider model done 33 cycles after start -> resp_valid=0001, coc=14, rec=2, err=00. Response holds until resp_ready[0].
- Signed operands, req 2: num=-100, den=7 -> coc=-14 (0xFFFFFFF2), rec=-2 (0xFFFFFFFE), err=00.
- All 4 requesters valid continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3. Exactly one req_ready pulse per grant and exactly one div_start per non-zero divide.
- Divide-by-zero, req 1: num=55, den=0 -> no div_start, resp_valid=0010 the cycle after grant, coc=0xFFFFFFFF, rec=55, err=01.
- Divider model never asserts done -> resp_valid 64 cycles after ISSUE with err=10, coc=0, rec=0. The next request is then served normally.
- Stuck-high done, plus a reset during WAIT: div_done left high from the previous op must not complete the new op in the ISSUE cycle. RSTa pulsed low during WAIT -> all outputs 0 immediately, FSM in IDLE, rr_ptr=0, no response issued for the aborted request.
